// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order retirement of tagged instructions.
// Captures rs/lsb CDB results, answers operand queries and flushes on mispredict.
module reorder_buffer #(
  parameter int ROB_SIZE     = 8,
  parameter int ROB_ID_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    dec2rob_en,
  input  logic [1:0]              dec_kind,
  input  logic [4:0]              dec_rd,
  input  logic [31:0]             dec_pred_pc,
  output logic                    rob_full,
  output logic [ROB_ID_WIDTH:0]   new_tag,
  input  logic [ROB_ID_WIDTH:0]   q1_lab,
  input  logic [ROB_ID_WIDTH:0]   q2_lab,
  output logic                    q1_ready,
  output logic                    q2_ready,
  output logic [31:0]             q1_val,
  output logic [31:0]             q2_val,
  input  logic                    rs_cdb_en,
  input  logic [ROB_ID_WIDTH:0]   rs_cdb2lab,
  input  logic [31:0]             rs_cdb2val,
  input  logic                    lsb_cdb_en,
  input  logic [ROB_ID_WIDTH:0]   lsb_cdb2lab,
  input  logic [31:0]             lsb_cdb2val,
  output logic                    commit_en,
  output logic [ROB_ID_WIDTH:0]   commit_lab,
  output logic [31:0]             commit_val,
  output logic [4:0]              commit_rd,
  output logic                    commit_store,
  output logic                    flush,
  output logic [31:0]             flush_pc
);

  localparam int LW = ROB_ID_WIDTH + 1;
  localparam logic [LW-1:0] SIZE_L = LW'(ROB_SIZE);

  typedef enum logic [1:0] {
    K_REG = 2'd0,
    K_BR  = 2'd1,
    K_ST  = 2'd2
  } kind_e;

  logic [ROB_SIZE-1:0]     valid_q, valid_d;
  logic [ROB_SIZE-1:0]     rdy_q, rdy_d;
  logic [1:0]              kind_q [ROB_SIZE];
  logic [1:0]              kind_d [ROB_SIZE];
  logic [4:0]              rd_q   [ROB_SIZE];
  logic [4:0]              rd_d   [ROB_SIZE];
  logic [31:0]             pc_q   [ROB_SIZE];
  logic [31:0]             pc_d   [ROB_SIZE];
  logic [31:0]             val_q  [ROB_SIZE];
  logic [31:0]             val_d  [ROB_SIZE];
  logic [ROB_ID_WIDTH-1:0] head_q, head_d;
  logic [ROB_ID_WIDTH-1:0] tail_q, tail_d;
  logic [LW-1:0]           count_q, count_d;

  logic                    commit_en_q, commit_en_d;
  logic [LW-1:0]           commit_lab_q, commit_lab_d;
  logic [31:0]             commit_val_q, commit_val_d;
  logic [4:0]              commit_rd_q, commit_rd_d;
  logic                    commit_store_q, commit_store_d;
  logic                    flush_q, flush_d;
  logic [31:0]             flush_pc_q, flush_pc_d;

  logic                    do_commit;
  logic                    do_alloc;
  logic                    mispredict;
  logic [ROB_ID_WIDTH-1:0] rs_idx, lsb_idx;
  logic                    rs_hit, lsb_hit;

  function automatic logic lab_ok(input logic [LW-1:0] lab);
    return (lab != '0) && (lab <= SIZE_L);
  endfunction

  function automatic logic [ROB_ID_WIDTH-1:0] lab2idx(
    input logic [LW-1:0] lab
  );
    logic [LW-1:0] t;
    t = lab - LW'(1);
    return t[ROB_ID_WIDTH-1:0];
  endfunction

  // {ready, value}; same-cycle CDB results bypass the stored entry
  function automatic logic [32:0] lookup(input logic [LW-1:0] lab);
    logic [ROB_ID_WIDTH-1:0] i;
    i = lab2idx(lab);
    if (lab == '0)
      return {1'b1, 32'h0};
    if (rs_cdb_en && rs_cdb2lab == lab)
      return {1'b1, rs_cdb2val};
    if (lsb_cdb_en && lsb_cdb2lab == lab)
      return {1'b1, lsb_cdb2val};
    if (lab_ok(lab) && valid_q[i] && rdy_q[i])
      return {1'b1, val_q[i]};
    return 33'h0;
  endfunction

  assign rob_full = (count_q == SIZE_L);
  assign new_tag  = {1'b0, tail_q} + LW'(1);

  always_comb begin
    {q1_ready, q1_val} = lookup(q1_lab);
    {q2_ready, q2_val} = lookup(q2_lab);
  end

  always_comb begin
    rs_idx  = lab2idx(rs_cdb2lab);
    lsb_idx = lab2idx(lsb_cdb2lab);
    rs_hit  = rs_cdb_en && lab_ok(rs_cdb2lab) && valid_q[rs_idx];
    lsb_hit = lsb_cdb_en && lab_ok(lsb_cdb2lab) && valid_q[lsb_idx];
    do_commit  = rdy_in && valid_q[head_q] && rdy_q[head_q];
    mispredict = do_commit && (kind_q[head_q] == K_BR)
              && (val_q[head_q] != pc_q[head_q]);
    do_alloc   = rdy_in && dec2rob_en && !rob_full;
  end

  always_comb begin
    valid_d        = valid_q;
    rdy_d          = rdy_q;
    kind_d         = kind_q;
    rd_d           = rd_q;
    pc_d           = pc_q;
    val_d          = val_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_en_d    = 1'b0;
    commit_store_d = 1'b0;
    flush_d        = 1'b0;
    commit_lab_d   = commit_lab_q;
    commit_val_d   = commit_val_q;
    commit_rd_d    = commit_rd_q;
    flush_pc_d     = flush_pc_q;

    if (rdy_in) begin
      // rs is applied last so it wins a same-label collision
      if (lsb_hit) begin
        rdy_d[lsb_idx] = 1'b1;
        val_d[lsb_idx] = lsb_cdb2val;
      end
      if (rs_hit) begin
        rdy_d[rs_idx] = 1'b1;
        val_d[rs_idx] = rs_cdb2val;
      end

      if (do_commit) begin
        valid_d[head_q] = 1'b0;
        rdy_d[head_q]   = 1'b0;
        head_d          = head_q + ROB_ID_WIDTH'(1);
        commit_en_d     = 1'b1;
        commit_lab_d    = {1'b0, head_q} + LW'(1);
        commit_val_d    = val_q[head_q];
        commit_rd_d     = (kind_q[head_q] == K_REG) ? rd_q[head_q] : 5'd0;
        commit_store_d  = (kind_q[head_q] == K_ST);
      end

      if (do_alloc) begin
        valid_d[tail_q] = 1'b1;
        rdy_d[tail_q]   = 1'b0;
        kind_d[tail_q]  = dec_kind;
        rd_d[tail_q]    = dec_rd;
        pc_d[tail_q]    = dec_pred_pc;
        tail_d          = tail_q + ROB_ID_WIDTH'(1);
      end

      count_d = count_q + LW'(do_alloc) - LW'(do_commit);

      if (mispredict) begin
        valid_d    = '0;
        rdy_d      = '0;
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
        flush_d    = 1'b1;
        flush_pc_d = val_q[head_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      valid_q        <= '0;
      rdy_q          <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_en_q    <= 1'b0;
      commit_lab_q   <= '0;
      commit_val_q   <= '0;
      commit_rd_q    <= '0;
      commit_store_q <= 1'b0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      valid_q        <= valid_d;
      rdy_q          <= rdy_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_en_q    <= commit_en_d;
      commit_lab_q   <= commit_lab_d;
      commit_val_q   <= commit_val_d;
      commit_rd_q    <= commit_rd_d;
      commit_store_q <= commit_store_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  // Entry payload needs no reset: valid/ready gate every use
  always_ff @(posedge clk) begin
    kind_q <= kind_d;
    rd_q   <= rd_d;
    pc_q   <= pc_d;
    val_q  <= val_d;
  end

  assign commit_en    = commit_en_q;
  assign commit_lab   = commit_lab_q;
  assign commit_val   = commit_val_q;
  assign commit_rd    = commit_rd_q;
  assign commit_store = commit_store_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer.
// Directed scenarios plus random traffic against a queue-based model.
module tb_reorder_buffer;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, dec2rob_en;
  logic [1:0]  dec_kind;
  logic [4:0]  dec_rd;
  logic [31:0] dec_pred_pc;
  logic        rob_full;
  logic [3:0]  new_tag;
  logic [3:0]  q1_lab, q2_lab;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_val, q2_val;
  logic        rs_cdb_en, lsb_cdb_en;
  logic [3:0]  rs_cdb2lab, lsb_cdb2lab;
  logic [31:0] rs_cdb2val, lsb_cdb2val;
  logic        commit_en, commit_store, flush;
  logic [3:0]  commit_lab;
  logic [31:0] commit_val, flush_pc;
  logic [4:0]  commit_rd;

  reorder_buffer #(.ROB_SIZE(8), .ROB_ID_WIDTH(3)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec2rob_en(dec2rob_en), .dec_kind(dec_kind), .dec_rd(dec_rd),
    .dec_pred_pc(dec_pred_pc), .rob_full(rob_full), .new_tag(new_tag),
    .q1_lab(q1_lab), .q2_lab(q2_lab),
    .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .rs_cdb_en(rs_cdb_en), .rs_cdb2lab(rs_cdb2lab), .rs_cdb2val(rs_cdb2val),
    .lsb_cdb_en(lsb_cdb_en), .lsb_cdb2lab(lsb_cdb2lab),
    .lsb_cdb2val(lsb_cdb2val),
    .commit_en(commit_en), .commit_lab(commit_lab),
    .commit_val(commit_val), .commit_rd(commit_rd),
    .commit_store(commit_store), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          lab;
    int          kind;
    int          rd;
    logic [31:0] pred;
    logic [31:0] val;
    bit          rdy;
  } ent_t;

  ent_t        mq[$];
  int          m_next;
  bit          e_commit, e_store, e_flush;
  int          e_lab, e_rd;
  logic [31:0] e_val, e_fpc;

  // Program-order queue: head retires once its result has arrived
  task automatic model_edge();
    bit full;
    ent_t h, n;
    e_commit = 0; e_store = 0; e_flush = 0;
    if (!rst_in) begin
      mq.delete(); m_next = 0;
      e_lab = 0; e_rd = 0; e_val = 0; e_fpc = 0;
      return;
    end
    if (!rdy_in) return;
    full = (mq.size() == N);
    if (mq.size() > 0 && mq[0].rdy) begin
      h = mq.pop_front();
      e_commit = 1; e_lab = h.lab; e_val = h.val;
      e_rd = (h.kind == 0) ? h.rd : 0;
      e_store = (h.kind == 2);
      if (h.kind == 1 && h.val != h.pred) begin
        e_flush = 1; e_fpc = h.val;
        mq.delete(); m_next = 0;
        return;
      end
    end
    foreach (mq[i]) begin
      if (lsb_cdb_en && lsb_cdb2lab != 0 && mq[i].lab == int'(lsb_cdb2lab)) begin
        mq[i].rdy = 1; mq[i].val = lsb_cdb2val;
      end
      if (rs_cdb_en && rs_cdb2lab != 0 && mq[i].lab == int'(rs_cdb2lab)) begin
        mq[i].rdy = 1; mq[i].val = rs_cdb2val;
      end
    end
    if (dec2rob_en && !full) begin
      n.lab = m_next + 1; n.kind = int'(dec_kind); n.rd = int'(dec_rd);
      n.pred = dec_pred_pc; n.val = 0; n.rdy = 0;
      mq.push_back(n);
      m_next = (m_next + 1) % N;
    end
  endtask

  function automatic logic [32:0] mquery(input logic [3:0] lab);
    if (lab == 0) return {1'b1, 32'h0};
    if (rs_cdb_en && rs_cdb2lab == lab) return {1'b1, rs_cdb2val};
    if (lsb_cdb_en && lsb_cdb2lab == lab) return {1'b1, lsb_cdb2val};
    foreach (mq[i])
      if (mq[i].lab == int'(lab))
        return {mq[i].rdy, mq[i].rdy ? mq[i].val : 32'h0};
    return 33'h0;
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    rst_in = 1; rdy_in = 1; dec2rob_en = 0;
    dec_kind = 0; dec_rd = 0; dec_pred_pc = 0;
    q1_lab = 0; q2_lab = 0;
    rs_cdb_en = 0; rs_cdb2lab = 0; rs_cdb2val = 0;
    lsb_cdb_en = 0; lsb_cdb2lab = 0; lsb_cdb2val = 0;
  endtask

  task automatic do_reset();
    clr_in();
    rst_in = 0;
    step();
    rst_in = 1;
  endtask

  task automatic alloc(input int kind, input int rd, input logic [31:0] pc);
    dec2rob_en = 1; dec_kind = 2'(kind); dec_rd = 5'(rd); dec_pred_pc = pc;
    step();
    dec2rob_en = 0;
  endtask

  task automatic rs_wr(input int lab, input logic [31:0] v);
    rs_cdb_en = 1; rs_cdb2lab = 4'(lab); rs_cdb2val = v;
  endtask

  task automatic lsb_wr(input int lab, input logic [31:0] v);
    lsb_cdb_en = 1; lsb_cdb2lab = 4'(lab); lsb_cdb2val = v;
  endtask

  task automatic cdb_off();
    rs_cdb_en = 0; lsb_cdb_en = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (commit_en !== 0 || commit_store !== 0 || flush !== 0) begin
      failures++;
      $display("FAIL reset_pulses got en=%b st=%b fl=%b want 0",
               commit_en, commit_store, flush);
    end
    checks++;
    if (commit_lab !== 0 || commit_val !== 0 || commit_rd !== 0 || flush_pc !== 0) begin
      failures++;
      $display("FAIL reset_data got lab=%0d val=%h rd=%0d fpc=%h want 0",
               commit_lab, commit_val, commit_rd, flush_pc);
    end
    checks++;
    if (new_tag !== 4'd1 || rob_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_tag got tag=%0d full=%b want 1/0", new_tag, rob_full);
    end
  endtask

  task automatic test_in_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (new_tag !== 4'(i + 1)) begin
        failures++;
        $display("FAIL inord_tag got %0d want %0d", new_tag, i + 1);
      end
      alloc(0, 5 + i, 0);
    end
    rs_wr(3, 32'h30); lsb_wr(2, 32'h20);
    step();
    cdb_off(); rs_wr(1, 32'h10);
    step();
    cdb_off();
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (commit_en !== (c < 3)) begin
        failures++;
        $display("FAIL inord_en cyc=%0d got %b want %b", c, commit_en, c < 3);
      end
      if (c < 3) begin
        checks++;
        if (commit_lab !== 4'(c + 1) || commit_val !== 32'((c + 1) * 16)
            || commit_rd !== 5'(5 + c)) begin
          failures++;
          $display("FAIL inord_data got lab=%0d val=%h rd=%0d want %0d/%h/%0d",
                   commit_lab, commit_val, commit_rd, c + 1, (c + 1) * 16, 5 + c);
        end
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < N; i++) alloc(0, i + 1, 0);
    checks++;
    if (rob_full !== 1 || new_tag !== 4'd1) begin
      failures++;
      $display("FAIL full_8 got full=%b tag=%0d want 1/1", rob_full, new_tag);
    end
    dec2rob_en = 1; dec_kind = 0; dec_rd = 5'd9;
    step();
    checks++;
    if (rob_full !== 1 || new_tag !== 4'd1 || commit_en !== 0) begin
      failures++;
      $display("FAIL full_9th got full=%b tag=%0d en=%b want 1/1/0",
               rob_full, new_tag, commit_en);
    end
    rs_wr(1, 32'h11);
    step();
    cdb_off();
    step();
    checks++;
    if (commit_en !== 1 || commit_lab !== 4'd1 || rob_full !== 0 || new_tag !== 4'd1) begin
      failures++;
      $display("FAIL full_commit got en=%b lab=%0d full=%b tag=%0d want 1/1/0/1",
               commit_en, commit_lab, rob_full, new_tag);
    end
    step();
    checks++;
    if (rob_full !== 1 || new_tag !== 4'd2 || commit_en !== 0) begin
      failures++;
      $display("FAIL full_realloc got full=%b tag=%0d en=%b want 1/2/0",
               rob_full, new_tag, commit_en);
    end
    dec2rob_en = 0;
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc(1, 0, 32'h100);
    alloc(0, 3, 0);
    alloc(2, 0, 0);
    rs_wr(2, 32'h22); lsb_wr(3, 32'h33);
    step();
    cdb_off(); rs_wr(1, 32'h200);
    step();
    cdb_off();
    dec2rob_en = 1; dec_kind = 0; dec_rd = 5'd4;
    rs_wr(2, 32'h99);
    step();
    dec2rob_en = 0; cdb_off();
    checks++;
    if (flush !== 1 || flush_pc !== 32'h200) begin
      failures++;
      $display("FAIL mis_flush got fl=%b pc=%h want 1/00000200", flush, flush_pc);
    end
    checks++;
    if (new_tag !== 4'd1 || rob_full !== 0) begin
      failures++;
      $display("FAIL mis_empty got tag=%0d full=%b want 1/0", new_tag, rob_full);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (commit_en !== 0 || flush !== 0) begin
        failures++;
        $display("FAIL mis_young got en=%b fl=%b want 0/0", commit_en, flush);
      end
    end
    for (int i = 0; i < N; i++) alloc(0, 1, 0);
    checks++;
    if (rob_full !== 1) begin
      failures++;
      $display("FAIL mis_count got full=%b want 1", rob_full);
    end
  endtask

  task automatic test_branch_ok();
    do_reset();
    alloc(1, 9, 32'h104);
    rs_wr(1, 32'h104);
    step();
    cdb_off();
    step();
    checks++;
    if (commit_en !== 1 || commit_rd !== 0 || flush !== 0 || commit_lab !== 4'd1) begin
      failures++;
      $display("FAIL br_ok got en=%b rd=%0d fl=%b lab=%0d want 1/0/0/1",
               commit_en, commit_rd, flush, commit_lab);
    end
  endtask

  task automatic test_query();
    do_reset();
    for (int i = 0; i < 3; i++) alloc(0, 1, 0);
    q1_lab = 3;
    #1;
    checks++;
    if (q1_ready !== 0) begin
      failures++;
      $display("FAIL q_notready got %b want 0", q1_ready);
    end
    q1_lab = 2; q2_lab = 0; rs_wr(2, 32'hABCD);
    #1;
    checks++;
    if (q1_ready !== 1 || q1_val !== 32'hABCD) begin
      failures++;
      $display("FAIL q_bypass got %b/%h want 1/0000abcd", q1_ready, q1_val);
    end
    checks++;
    if (q2_ready !== 1 || q2_val !== 0) begin
      failures++;
      $display("FAIL q_zero got %b/%h want 1/0", q2_ready, q2_val);
    end
    q2_lab = 3; lsb_wr(3, 32'h55);
    #1;
    checks++;
    if (q2_ready !== 1 || q2_val !== 32'h55) begin
      failures++;
      $display("FAIL q_lsb got %b/%h want 1/00000055", q2_ready, q2_val);
    end
    step();
    cdb_off();
    #1;
    checks++;
    if (q1_ready !== 1 || q1_val !== 32'hABCD) begin
      failures++;
      $display("FAIL q_stored got %b/%h want 1/0000abcd", q1_ready, q1_val);
    end
    q1_lab = 0; q2_lab = 0;
  endtask

  task automatic test_rdy_stall();
    do_reset();
    alloc(0, 4, 0);
    rs_wr(1, 32'h44);
    step();
    cdb_off();
    rdy_in = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (commit_en !== 0) begin
        failures++;
        $display("FAIL stall_en cyc=%0d got %b want 0", c, commit_en);
      end
    end
    rdy_in = 1;
    step();
    checks++;
    if (commit_en !== 1 || commit_lab !== 4'd1 || commit_val !== 32'h44) begin
      failures++;
      $display("FAIL stall_release got en=%b lab=%0d val=%h want 1/1/00000044",
               commit_en, commit_lab, commit_val);
    end
    for (int i = 0; i < 3; i++) alloc(2, 0, 0);
    rs_wr(2, 32'h77);
    step();
    cdb_off();
    rst_in = 0;
    step();
    rst_in = 1;
    checks++;
    if (commit_en !== 0 || flush !== 0 || commit_lab !== 0 || commit_val !== 0
        || commit_rd !== 0 || flush_pc !== 0 || commit_store !== 0) begin
      failures++;
      $display("FAIL midrst_outs got en=%b fl=%b lab=%0d val=%h want all 0",
               commit_en, flush, commit_lab, commit_val);
    end
    checks++;
    if (new_tag !== 4'd1 || rob_full !== 0) begin
      failures++;
      $display("FAIL midrst_tag got tag=%0d full=%b want 1/0", new_tag, rob_full);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (commit_en !== 0) begin
        failures++;
        $display("FAIL midrst_stale got en=%b want 0", commit_en);
      end
    end
  endtask

  task automatic test_random();
    logic [32:0] r;
    int k;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rdy_in = ($urandom % 10) != 0;
      dec2rob_en = ($urandom % 2) != 0;
      k = $urandom % 6;
      dec_kind = (k < 3) ? 2'd0 : (k == 3) ? 2'd1 : 2'd2;
      dec_rd = 5'($urandom);
      dec_pred_pc = ($urandom % 2) ? 32'h100 : 32'h200;
      rs_cdb_en = ($urandom % 3) != 0;
      lsb_cdb_en = ($urandom % 3) != 0;
      if (mq.size() > 0 && ($urandom % 4) != 0)
        rs_cdb2lab = 4'(mq[$urandom_range(0, mq.size() - 1)].lab);
      else
        rs_cdb2lab = 4'($urandom);
      if (mq.size() > 0 && ($urandom % 4) != 0)
        lsb_cdb2lab = 4'(mq[$urandom_range(0, mq.size() - 1)].lab);
      else
        lsb_cdb2lab = 4'($urandom);
      k = $urandom % 3;
      rs_cdb2val = (k == 0) ? 32'h100 : (k == 1) ? 32'h200 : $urandom;
      k = $urandom % 3;
      lsb_cdb2val = (k == 0) ? 32'h100 : (k == 1) ? 32'h200 : $urandom;
      q1_lab = 4'($urandom_range(0, 9));
      q2_lab = 4'($urandom_range(0, 9));
      #1;
      r = mquery(q1_lab);
      checks++;
      if (q1_ready !== r[32] || (r[32] && q1_val !== r[31:0])) begin
        failures++;
        $display("FAIL rnd_q1 lab=%0d got %b/%h want %b/%h",
                 q1_lab, q1_ready, q1_val, r[32], r[31:0]);
      end
      r = mquery(q2_lab);
      checks++;
      if (q2_ready !== r[32] || (r[32] && q2_val !== r[31:0])) begin
        failures++;
        $display("FAIL rnd_q2 lab=%0d got %b/%h want %b/%h",
                 q2_lab, q2_ready, q2_val, r[32], r[31:0]);
      end
      step();
      checks++;
      if (commit_en !== e_commit || flush !== e_flush) begin
        failures++;
        $display("FAIL rnd_pulse cyc=%0d got en=%b fl=%b want %b/%b",
                 c, commit_en, flush, e_commit, e_flush);
      end
      if (e_commit) begin
        checks++;
        if (commit_lab !== 4'(e_lab) || commit_val !== e_val
            || commit_rd !== 5'(e_rd) || commit_store !== e_store) begin
          failures++;
          $display("FAIL rnd_commit got %0d/%h/%0d/%b want %0d/%h/%0d/%b",
                   commit_lab, commit_val, commit_rd, commit_store,
                   e_lab, e_val, e_rd, e_store);
        end
      end
      if (e_flush) begin
        checks++;
        if (flush_pc !== e_fpc) begin
          failures++;
          $display("FAIL rnd_fpc got %h want %h", flush_pc, e_fpc);
        end
      end
      checks++;
      if (new_tag !== 4'(m_next + 1) || rob_full !== (mq.size() == N)) begin
        failures++;
        $display("FAIL rnd_alloc got tag=%0d full=%b want %0d/%b",
                 new_tag, rob_full, m_next + 1, mq.size() == N);
      end
    end
  endtask

  initial begin
    clr_in();
    mq.delete();
    m_next = 0;
    test_reset();
    test_in_order();
    test_full();
    test_mispredict();
    test_branch_ok();
    test_query();
    test_rdy_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
